locked_reg_access_arbiter: RTL

- Shares one lockable 16-bit configuration register between NUM_REQ bus requesters.
- Round-robin arbitration of write requests.
- Sticky lock: once set, only resetn clears it.
- Per-write permission check against lock_status, scan_mode and debug_unlocked, returned to the winner as ack/denied.
- Sits between the requesters and the protected register; it is the only write path into Data_out.

---
 rtl/locked_reg_access_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/locked_reg_access_arbiter.sv
// Purpose : Round-robin write arbiter in front of one lockable configuration
//           register. Each winning write is checked against the sticky lock,
//           scan_mode and debug_unlocked, and answered with ack/denied.
// Ports   : Clk, resetn (async active-low)
//           req[NUM_REQ]        per-requester level write request
//           wr_data[NUM_REQ*DW] flattened write data, slice i = [i*DW +: DW]
//           lock_req            sets the sticky lock
//           scan_mode           blocks grants and writes
//           debug_unlocked      permits writes while locked (not in scan)
//           gnt, ack, denied    one-hot grant, completion pulse, reject flag
//           Data_out            protected register contents
//           lock_status         sticky lock state
// Option  : define LOCK_VIOLATION_LOG_EN to add viol_count / viol_id outputs.
module locked_reg_access_arbiter #(
    parameter int unsigned    NUM_REQ   = 4,
    parameter int unsigned    DW        = 16,
    parameter logic [DW-1:0]  RESET_VAL = '0
) (
    input  logic                      Clk,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DW-1:0]     wr_data,
    input  logic                      lock_req,
    input  logic                      scan_mode,
    input  logic                      debug_unlocked,
`ifdef LOCK_VIOLATION_LOG_EN
    output logic [7:0]                viol_count,
    output logic [$clog2(NUM_REQ)-1:0] viol_id,
`endif
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      ack,
    output logic                      denied,
    output logic [DW-1:0]             Data_out,
    output logic                      lock_status
);

    localparam int unsigned   IDW    = $clog2(NUM_REQ);
    localparam logic [IDW:0]  NREQ_W = (IDW+1)'(NUM_REQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, GRANT, COMMIT, RESP} state_t;

    state_t              r_state;
    logic [IDW-1:0]      r_ptr;
    logic [IDW-1:0]      r_win;
    logic [NUM_REQ-1:0]  r_gnt;
    logic                r_ack;
    logic                r_denied;
    logic [DW-1:0]       r_buf;
    logic [DW-1:0]       r_data;
    logic                r_lock;

    logic                w_found;
    logic [IDW-1:0]      w_pick;
    logic [DW-1:0]       w_wdata;
    logic                w_allow;

    // Offset from the round-robin pointer, wrapped modulo NUM_REQ.
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                                input int unsigned    off);
        logic [IDW:0] s;
        s = {1'b0, base} + (IDW+1)'(off);
        if (s >= NREQ_W) s = s - NREQ_W;
        return s[IDW-1:0];
    endfunction

    // First requesting index at or above the pointer.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req[wrap_idx(r_ptr, k)]) begin
                w_found = 1'b1;
                w_pick  = wrap_idx(r_ptr, k);
            end
        end
    end

    // Winner's write data slice.
    always_comb begin
        w_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_win == IDW'(i)) w_wdata = wr_data[i*DW +: DW];
        end
    end

    // A lock_req on the commit edge already counts as locked.
    assign w_allow = ~scan_mode & (~(r_lock | lock_req) | debug_unlocked);

`ifdef LOCK_VIOLATION_LOG_EN
    logic [7:0]     r_viol_cnt;
    logic [IDW-1:0] r_viol_id;

    // Denied-commit logger, saturating.
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            r_viol_cnt <= 8'd0;
            r_viol_id  <= '0;
        end else if (r_state == COMMIT && !w_allow) begin
            if (r_viol_cnt != 8'hFF) r_viol_cnt <= r_viol_cnt + 8'd1;
            r_viol_id <= r_win;
        end
    end

    assign viol_count = r_viol_cnt;
    assign viol_id    = r_viol_id;
`endif

    // Transaction FSM with registered outputs; sticky lock runs alongside.
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_win    <= '0;
            r_gnt    <= '0;
            r_ack    <= 1'b0;
            r_denied <= 1'b0;
            r_buf    <= '0;
            r_data   <= RESET_VAL;
            r_lock   <= 1'b0;
        end else begin
            if (lock_req) r_lock <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_found && !scan_mode) begin
                        r_gnt   <= NUM_REQ'(1) << w_pick;
                        r_win   <= w_pick;
                        r_state <= GRANT;
                    end else begin
                        r_gnt <= '0;
                    end
                end
                GRANT: begin
                    r_buf   <= w_wdata;
                    r_state <= COMMIT;
                end
                COMMIT: begin
                    if (w_allow) r_data <= r_buf;
                    r_ack    <= 1'b1;
                    r_denied <= ~w_allow;
                    r_state  <= RESP;
                end
                RESP: begin
                    r_ack    <= 1'b0;
                    r_denied <= 1'b0;
                    r_gnt    <= '0;
                    r_ptr    <= (r_win == LAST_ID) ? '0 : r_win + IDW'(1);
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign ack         = r_ack;
    assign denied      = r_denied;
    assign Data_out    = r_data;
    assign lock_status = r_lock;

endmodule
